// File: rtl/resp_checker_pkg.sv
// Shared types and width helpers for the response checker.
package resp_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int idx_w(input int depth);
    return ($clog2(depth) < 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/resp_check_timer.sv
// Idle-cycle counter: counts enabled cycles since the last clear, flags LIMIT idle cycles.
module resp_check_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = ($clog2(LIMIT) < 1) ? 1 : $clog2(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && !clr_i && (cnt_q == CW'(LIMIT - 1));

  // Hold at the limit once expired; the owner leaves RUN on that edge.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/resp_checker.sv
// Compares a stream of response beats against an elaboration-time golden table.
// Optional idle timeout enabled by defining RESP_CHECK_TIMEOUT_EN.
module resp_checker
  import resp_checker_pkg::*;
#(
  parameter int                       WIDTH    = 1,
  parameter int                       DEPTH    = 4,
  parameter logic [DEPTH*WIDTH-1:0]   EXPECTED = 4'b0111,
  parameter int                       TIMEOUT  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic [WIDTH-1:0]            in_data,
  output logic                        in_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic                        mismatch,
  output logic [cnt_w(DEPTH)-1:0]     err_count,
  output logic [idx_w(DEPTH)-1:0]     first_fail_idx,
  output logic                        first_fail_vld,
  output logic                        timed_out
);

  localparam int CW = cnt_w(DEPTH);
  localparam int IW = idx_w(DEPTH);

  state_e          state_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   err_q;
  logic [IW-1:0]   ffi_q;
  logic            ffv_q;
  logic            mism_q;
  logic            to_q;

  logic            accept;
  logic            beat_bad;
  logic            last_beat;
  logic            run_entry;
  logic            tmr_expire;
  logic [WIDTH-1:0] exp_beat;

  assign accept    = (state_q == RUN) && in_valid;
  assign exp_beat  = EXPECTED[int'(idx_q)*WIDTH +: WIDTH];
  assign beat_bad  = (in_data != exp_beat);
  assign last_beat = (idx_q == IW'(DEPTH - 1));
  assign run_entry = (state_q != RUN) && start;

`ifdef RESP_CHECK_TIMEOUT_EN
  resp_check_timer #(
    .LIMIT    (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (accept || run_entry),
    .en_i     (state_q == RUN),
    .expire_o (tmr_expire)
  );
`else
  assign tmr_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
      mism_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      mism_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          // first_fail_idx is left alone; first_fail_vld says whether it is current.
          if (start) begin
            state_q <= RUN;
            idx_q   <= '0;
            err_q   <= '0;
            ffv_q   <= 1'b0;
            to_q    <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            if (beat_bad) begin
              mism_q <= 1'b1;
              if (err_q != CW'(DEPTH)) begin
                err_q <= err_q + CW'(1);
              end
              if (!ffv_q) begin
                ffi_q <= idx_q;
                ffv_q <= 1'b1;
              end
            end
            if (last_beat) begin
              state_q <= DONE;
              idx_q   <= '0;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end else if (tmr_expire) begin
            state_q <= DONE;
            to_q    <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready       = (state_q == RUN);
  assign busy           = (state_q == RUN);
  assign done           = (state_q == DONE);
  assign pass           = (state_q == DONE) && (err_q == '0) && !to_q;
  assign mismatch       = mism_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign first_fail_vld = ffv_q;
  assign timed_out      = to_q;

endmodule
